// File: rtl/countdown_timer.sv
// Game countdown timer: BCD M:SS digits decremented at a strike-dependent rate,
// with pause, permanent halt and a sticky expiry flag for the game-loss logic.
module countdown_timer #(
    parameter int CLK_HZ     = 27000000,
    parameter int START_MIN  = 5,
    parameter int START_TENS = 0,
    parameter int START_ONES = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       halt,
    input  logic [1:0] strikes,
    output logic [3:0] minutes,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       tick,
    output logic       explode_timer
);

    localparam int LIM0_RAW = CLK_HZ;
    localparam int LIM1_RAW = (CLK_HZ * 4) / 5;
    localparam int LIM2_RAW = (CLK_HZ * 2) / 3;
    localparam int LIM3_RAW = CLK_HZ / 2;
    localparam int LIM0     = (LIM0_RAW < 1) ? 1 : LIM0_RAW;
    localparam int LIM1     = (LIM1_RAW < 1) ? 1 : LIM1_RAW;
    localparam int LIM2     = (LIM2_RAW < 1) ? 1 : LIM2_RAW;
    localparam int LIM3     = (LIM3_RAW < 1) ? 1 : LIM3_RAW;
    localparam int PW       = (LIM0 > 2) ? $clog2(LIM0) : 1;

    localparam logic [PW-1:0] TOP0 = PW'(LIM0 - 1);
    localparam logic [PW-1:0] TOP1 = PW'(LIM1 - 1);
    localparam logic [PW-1:0] TOP2 = PW'(LIM2 - 1);
    localparam logic [PW-1:0] TOP3 = PW'(LIM3 - 1);

    localparam logic [3:0] ST_MIN  = 4'(START_MIN);
    localparam logic [2:0] ST_TENS = 3'(START_TENS);
    localparam logic [3:0] ST_ONES = 4'(START_ONES);
    localparam logic       ST_ZERO = (ST_MIN == 4'd0) && (ST_TENS == 3'd0) && (ST_ONES == 4'd0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSED  = 3'd2,
        EXPIRED = 3'd3,
        HALTED  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [PW-1:0] top_s;
    logic [3:0]    min_r, min_s;
    logic [2:0]    tens_r, tens_s;
    logic [3:0]    ones_r, ones_s;
    logic          running_r;
    logic          tick_r, tick_s;
    logic          explode_r, explode_s;
    logic [10:0]   dec_s;

    // One-second BCD borrow chain on M:SS digits, packed as {min, tens, ones}.
    function automatic logic [10:0] bcd_dec(input logic [3:0] m, input logic [2:0] t,
                                            input logic [3:0] o);
        logic [3:0] m_n;
        logic [2:0] t_n;
        logic [3:0] o_n;
        if (o != 4'd0) begin
            o_n = o - 4'd1;
            t_n = t;
            m_n = m;
        end else if (t != 3'd0) begin
            o_n = 4'd9;
            t_n = t - 3'd1;
            m_n = m;
        end else begin
            o_n = 4'd9;
            t_n = 3'd5;
            m_n = m - 4'd1;
        end
        return {m_n, t_n, o_n};
    endfunction

    // Prescaler terminal value for the current strike count.
    always_comb begin
        top_s = TOP0;
        case (strikes)
            2'd0:    top_s = TOP0;
            2'd1:    top_s = TOP1;
            2'd2:    top_s = TOP2;
            2'd3:    top_s = TOP3;
            default: top_s = TOP0;
        endcase
    end

    // Next-state, prescaler and digit logic; halt beats pause beats decrement.
    always_comb begin
        state_s   = state_r;
        presc_s   = presc_r;
        min_s     = min_r;
        tens_s    = tens_r;
        ones_s    = ones_r;
        tick_s    = 1'b0;
        explode_s = explode_r;
        dec_s     = bcd_dec(min_r, tens_r, ones_r);
        case (state_r)
            IDLE: begin
                min_s  = ST_MIN;
                tens_s = ST_TENS;
                ones_s = ST_ONES;
                if (halt) begin
                    state_s = HALTED;
                end else if (start) begin
                    presc_s = {PW{1'b0}};
                    if (ST_ZERO) begin
                        state_s   = EXPIRED;
                        explode_s = 1'b1;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    presc_s = presc_r;
                end
            end
            RUN: begin
                if (halt) begin
                    state_s = HALTED;
                end else if (pause) begin
                    state_s = PAUSED;
                end else if (presc_r >= top_s) begin
                    // >= also covers a strike change that lowers the limit below the count
                    presc_s = {PW{1'b0}};
                    tick_s  = 1'b1;
                    min_s   = dec_s[10:7];
                    tens_s  = dec_s[6:4];
                    ones_s  = dec_s[3:0];
                    if (dec_s == 11'd0) begin
                        state_s   = EXPIRED;
                        explode_s = 1'b1;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    presc_s = presc_r + PW'(1);
                end
            end
            PAUSED: begin
                if (halt) begin
                    state_s = HALTED;
                end else if (!pause) begin
                    state_s = RUN;
                end else begin
                    state_s = PAUSED;
                end
            end
            EXPIRED: begin
                min_s     = 4'd0;
                tens_s    = 3'd0;
                ones_s    = 4'd0;
                explode_s = 1'b1;
            end
            HALTED: begin
                state_s = HALTED;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the start values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            presc_r   <= {PW{1'b0}};
            min_r     <= ST_MIN;
            tens_r    <= ST_TENS;
            ones_r    <= ST_ONES;
            running_r <= 1'b0;
            tick_r    <= 1'b0;
            explode_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            min_r     <= min_s;
            tens_r    <= tens_s;
            ones_r    <= ones_s;
            running_r <= (state_s == RUN);
            tick_r    <= tick_s;
            explode_r <= explode_s;
        end
    end

    assign minutes       = min_r;
    assign sec_tens      = tens_r;
    assign sec_ones      = ones_r;
    assign running       = running_r;
    assign tick          = tick_r;
    assign explode_timer = explode_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: CLK_HZ=10 with start values 0:12, 0:00 and 9:59.
module tb_countdown_timer;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       pause   = 1'b0;
    logic       halt    = 1'b0;
    logic [1:0] strikes = 2'd0;
    logic       start_a = 1'b0;
    logic       start_z = 1'b0;
    logic       start_b = 1'b0;

    logic [3:0] min_a, min_z, min_b;
    logic [2:0] tens_a, tens_z, tens_b;
    logic [3:0] ones_a, ones_z, ones_b;
    logic       running_a, running_z, running_b;
    logic       tick_a, tick_z, tick_b;
    logic       explode_a, explode_z, explode_b;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int ticks_seen;
    int run_seen;

    always #5 clock = ~clock;

    countdown_timer #(.CLK_HZ(10), .START_MIN(0), .START_TENS(1), .START_ONES(2)) u_a (
        .clock(clock), .reset(reset), .start(start_a), .pause(pause), .halt(halt),
        .strikes(strikes), .minutes(min_a), .sec_tens(tens_a), .sec_ones(ones_a),
        .running(running_a), .tick(tick_a), .explode_timer(explode_a));

    countdown_timer #(.CLK_HZ(10), .START_MIN(0), .START_TENS(0), .START_ONES(0)) u_z (
        .clock(clock), .reset(reset), .start(start_z), .pause(pause), .halt(halt),
        .strikes(strikes), .minutes(min_z), .sec_tens(tens_z), .sec_ones(ones_z),
        .running(running_z), .tick(tick_z), .explode_timer(explode_z));

    countdown_timer #(.CLK_HZ(10), .START_MIN(9), .START_TENS(5), .START_ONES(9)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .pause(pause), .halt(halt),
        .strikes(strikes), .minutes(min_b), .sec_tens(tens_b), .sec_ones(ones_b),
        .running(running_b), .tick(tick_b), .explode_timer(explode_b));

    task automatic chk_eq(input string tag, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Expected display for a remaining-seconds count, as decimal M*100+T*10+O.
    function automatic int secs_disp(input int s);
        return (s / 60) * 100 + ((s % 60) / 10) * 10 + (s % 10);
    endfunction

    function automatic int disp_a();
        return int'(min_a) * 100 + int'(tens_a) * 10 + int'(ones_a);
    endfunction

    function automatic int disp_z();
        return int'(min_z) * 100 + int'(tens_z) * 10 + int'(ones_z);
    endfunction

    function automatic int disp_b();
        return int'(min_b) * 100 + int'(tens_b) * 10 + int'(ones_b);
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic start_run_a();
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
    endtask

    initial begin
        // asynchronous reset state, checked before any clock edge
        #2 reset = 1'b0;
        #1;
        chk_eq("rst_disp_a", disp_a(), 12);
        chk_eq("rst_run_a", int'(running_a), 0);
        chk_eq("rst_tick_a", int'(tick_a), 0);
        chk_eq("rst_expl_a", int'(explode_a), 0);
        chk_eq("rst_disp_b", disp_b(), 959);
        cyc(2);
        reset = 1'b1;
        cyc(1);

        // nominal expiry at strikes=0: a tick every 10 cycles
        strikes = 2'd0;
        start_run_a();
        chk_eq("s1_running", int'(running_a), 1);
        chk_eq("s1_disp0", disp_a(), 12);
        for (int k = 1; k <= 12; k++) begin
            cyc(9);
            chk_eq("s1_gap_tick", int'(tick_a), 0);
            chk_eq("s1_gap_disp", disp_a(), secs_disp(13 - k));
            cyc(1);
            chk_eq("s1_tick", int'(tick_a), 1);
            chk_eq("s1_disp", disp_a(), secs_disp(12 - k));
            chk_eq("s1_expl", int'(explode_a), (k == 12) ? 1 : 0);
        end
        cyc(5);
        chk_eq("s1_hold_expl", int'(explode_a), 1);
        chk_eq("s1_hold_tick", int'(tick_a), 0);
        chk_eq("s1_hold_run", int'(running_a), 0);
        chk_eq("s1_hold_disp", disp_a(), 0);

        // asynchronous reset while EXPIRED
        #2 reset = 1'b0;
        #1;
        chk_eq("s5_exp_rst_disp", disp_a(), 12);
        chk_eq("s5_exp_rst_expl", int'(explode_a), 0);
        chk_eq("s5_exp_rst_run", int'(running_a), 0);
        cyc(1);
        reset = 1'b1;
        cyc(1);

        // strikes=3: a tick every 5 cycles, expiry after 60
        strikes = 2'd3;
        start_run_a();
        for (int k = 1; k <= 12; k++) begin
            cyc(4);
            chk_eq("s2_gap_tick", int'(tick_a), 0);
            cyc(1);
            chk_eq("s2_tick", int'(tick_a), 1);
            chk_eq("s2_disp", disp_a(), secs_disp(12 - k));
        end
        chk_eq("s2_expl", int'(explode_a), 1);

        // strikes 0->2 with the prescaler at 8: immediate tick, then every 6
        do_reset();
        strikes = 2'd0;
        start_run_a();
        cyc(8);
        chk_eq("s2b_pre_tick", int'(tick_a), 0);
        strikes = 2'd2;
        cyc(1);
        chk_eq("s2b_imm_tick", int'(tick_a), 1);
        chk_eq("s2b_imm_disp", disp_a(), 11);
        cyc(5);
        chk_eq("s2b_gap_tick", int'(tick_a), 0);
        cyc(1);
        chk_eq("s2b_tick6", int'(tick_a), 1);
        chk_eq("s2b_disp6", disp_a(), 10);

        // pause for 37 cycles with the prescaler at 4
        do_reset();
        strikes = 2'd0;
        start_run_a();
        cyc(4);
        pause      = 1'b1;
        ticks_seen = 0;
        run_seen   = 0;
        for (int i = 0; i < 37; i++) begin
            cyc(1);
            ticks_seen += int'(tick_a);
            run_seen   += int'(running_a);
        end
        chk_eq("s3_pause_ticks", ticks_seen, 0);
        chk_eq("s3_pause_run", run_seen, 0);
        chk_eq("s3_pause_disp", disp_a(), 12);
        pause = 1'b0;
        cyc(1);
        chk_eq("s3_resume_run", int'(running_a), 1);
        cyc(5);
        chk_eq("s3_resume_gap", int'(tick_a), 0);
        cyc(1);
        chk_eq("s3_resume_tick", int'(tick_a), 1);
        chk_eq("s3_resume_disp", disp_a(), 11);

        // pause on the decrement cycle defers the tick past resume
        cyc(9);
        chk_eq("s3c_pre_tick", int'(tick_a), 0);
        pause = 1'b1;
        cyc(1);
        chk_eq("s3c_pause_tick", int'(tick_a), 0);
        chk_eq("s3c_pause_disp", disp_a(), 11);
        chk_eq("s3c_pause_run", int'(running_a), 0);
        cyc(3);
        pause = 1'b0;
        cyc(1);
        chk_eq("s3c_resume_tick", int'(tick_a), 0);
        chk_eq("s3c_resume_run", int'(running_a), 1);
        cyc(1);
        chk_eq("s3c_late_tick", int'(tick_a), 1);
        chk_eq("s3c_late_disp", disp_a(), 10);

        // halt at 0:05, start ignored, halt released still frozen
        do_reset();
        strikes = 2'd3;
        start_run_a();
        cyc(35);
        chk_eq("s4_at5", disp_a(), 5);
        halt = 1'b1;
        cyc(1);
        chk_eq("s4_halt_run", int'(running_a), 0);
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        cyc(50);
        chk_eq("s4_halt_disp", disp_a(), 5);
        chk_eq("s4_halt_expl", int'(explode_a), 0);
        chk_eq("s4_halt_run2", int'(running_a), 0);
        halt = 1'b0;
        cyc(20);
        chk_eq("s4_rel_disp", disp_a(), 5);
        chk_eq("s4_rel_run", int'(running_a), 0);

        // halt coinciding with the 0:01 -> 0:00 decrement
        do_reset();
        strikes = 2'd3;
        start_run_a();
        cyc(55);
        chk_eq("s4b_at1", disp_a(), 1);
        cyc(4);
        halt = 1'b1;
        cyc(1);
        chk_eq("s4b_tick", int'(tick_a), 0);
        chk_eq("s4b_disp", disp_a(), 1);
        chk_eq("s4b_expl", int'(explode_a), 0);
        cyc(10);
        chk_eq("s4b_expl_late", int'(explode_a), 0);
        chk_eq("s4b_disp_late", disp_a(), 1);
        halt = 1'b0;

        // asynchronous reset mid-RUN at 0:07, then a normal restart
        do_reset();
        strikes = 2'd3;
        start_run_a();
        cyc(25);
        chk_eq("s5_at7", disp_a(), 7);
        cyc(2);
        #2 reset = 1'b0;
        #1;
        chk_eq("s5_run_rst_disp", disp_a(), 12);
        chk_eq("s5_run_rst_run", int'(running_a), 0);
        chk_eq("s5_run_rst_expl", int'(explode_a), 0);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        start_run_a();
        cyc(4);
        chk_eq("s5_restart_gap", int'(tick_a), 0);
        cyc(1);
        chk_eq("s5_restart_tick", int'(tick_a), 1);
        chk_eq("s5_restart_disp", disp_a(), 11);

        // boundary starts: 0:00 expires immediately; 9:59 borrow chain
        do_reset();
        strikes = 2'd0;
        chk_eq("s6_z_idle_expl", int'(explode_z), 0);
        start_z = 1'b1;
        cyc(1);
        start_z = 1'b0;
        chk_eq("s6_z_expl", int'(explode_z), 1);
        chk_eq("s6_z_tick", int'(tick_z), 0);
        chk_eq("s6_z_run", int'(running_z), 0);
        chk_eq("s6_z_disp", disp_z(), 0);
        cyc(3);
        chk_eq("s6_z_hold", int'(explode_z), 1);

        start_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        chk_eq("s6_b_run", int'(running_b), 1);
        for (int k = 1; k <= 60; k++) begin
            cyc(10);
            chk_eq("s6_b_tick", int'(tick_b), 1);
            chk_eq("s6_b_disp", disp_b(), secs_disp(599 - k));
        end
        chk_eq("s6_b_expl", int'(explode_b), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- CLK_HZ, 27000000, clock cycles per nominal second.
- START_MIN, 5, initial minutes digit (BCD, 0-9).
- START_TENS, 0, initial seconds-tens digit (BCD, 0-5).
- START_ONES, 0, initial seconds-ones digit (BCD, 0-9).

REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports, one per line: name, direction, width, meaning.
- clock, in, 1, system clock; all state on rising edge.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse; arms and starts the countdown.
- pause, in, 1, level; freezes the count while high.
- halt, in, 1, level; game ended elsewhere (defused or lost); freezes permanently.
- strikes, in, 2, current strike count 0-3; selects the count rate.
- minutes, out, 4, BCD minutes digit.
- sec_tens, out, 3, BCD seconds-tens digit.
- sec_ones, out, 4, BCD seconds-ones digit.
- running, out, 1, high in RUN state.
- tick, out, 1, one-cycle pulse on every decrement (beeper/LED).
- explode_timer, out, 1, sticky level; high once time reaches 0:00; feeds the game-loss block.

Function
REQ-003 The FSM SHALL have states IDLE, RUN, PAUSED, EXPIRED, and HALTED; reset enters IDLE.
REQ-004 IDLE SHALL hold the digits at START_MIN:START_TENS START_ONES; start moves to RUN and clears the prescaler.
REQ-005 RUN SHALL go to PAUSED when pause=1; PAUSED SHALL return to RUN when pause=0, resuming the prescaler unchanged.
REQ-006 halt=1 in IDLE, RUN, or PAUSED SHALL go to HALTED on the next edge, freezing the digits; HALTED and EXPIRED SHALL exit only via reset.
REQ-007 The prescaler SHALL count cycles in RUN only and generate a decrement when it reaches LIMIT-1, then wrap to 0.
- LIMIT = CLK_HZ for strikes=0.
- LIMIT = CLK_HZ*4/5 for strikes=1.
- LIMIT = CLK_HZ*2/3 for strikes=2.
- LIMIT = CLK_HZ/2 for strikes=3.
- All limits are computed at elaboration.
REQ-008 If strikes changes so that prescaler >= new LIMIT-1, the decrement SHALL occur on the next edge, and the prescaler SHALL wrap to 0.
REQ-009 Each decrement SHALL assert tick for exactly that cycle and perform a BCD borrow chain.
- ones 0 -> 9, with a borrow from tens.
- tens 0 -> 5, with a borrow from minutes.
- minutes decrements by 1.
REQ-010 The decrement that produces 0:00 SHALL enter EXPIRED and set explode_timer on the same clock edge that the digits become 0:00.
REQ-011 In EXPIRED, the digits SHALL hold at 0:00, with running=0, tick=0, and explode_timer=1 until reset.
REQ-012 If halt and a decrement coincide, halt SHALL win: no decrement, no tick, and explode_timer stays 0.
REQ-013 If pause and a decrement coincide, pause SHALL win: the prescaler holds at LIMIT-1, and the decrement fires on the first RUN cycle after resume.
REQ-014 start SHALL be ignored in every state except IDLE.
REQ-015 If the start digits are 0:00, start SHALL enter EXPIRED directly and set explode_timer on the next edge.
REQ-016 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-017 reset low SHALL immediately, without a clock, set the following:
- State IDLE, prescaler 0.
- Digits at the START values.
- running, tick, and explode_timer at 0.
REQ-018 Reset asserted mid-RUN or in EXPIRED SHALL abort and restore the REQ-017 values; release SHALL be synchronous to the next rising edge.

Verification
All scenarios use CLK_HZ=10, START=0:12.
REQ-019 Scenario 1, nominal expiry.
- Stimulus: start with strikes=0.
- Response: 12 ticks spaced 10 cycles apart; the digits pass through 0:11, 0:10, 0:09 (borrow), down to 0:00.
- Response: explode_timer rises with 0:00, about 120 cycles after start, and stays high.
REQ-020 Scenario 2, strike speed-up.
- Stimulus: strikes=3 from start.
- Response: ticks every 5 cycles, and explode_timer after about 60 cycles.
- Stimulus: change strikes 0->2 with the prescaler at 8.
- Response: a tick on the next edge, after which ticks are 6 cycles apart.
REQ-021 Scenario 3, pause.
- Stimulus: pause for 37 cycles mid-count.
- Response: digits and tick frozen, running=0; the count resumes with the elapsed prescaler value preserved.
- Stimulus: pause coinciding with the decrement cycle.
- Response: the tick is deferred as REQ-013 requires.
REQ-022 Scenario 4, halt races.
- Stimulus: halt at 0:05.
- Response: frozen at 0:05; explode_timer never rises; start is ignored.
- Stimulus: halt on the same cycle as the 0:01->0:00 decrement.
- Response: holds 0:01, with explode_timer=0.
REQ-023 Scenario 5, asynchronous reset.
- Stimulus: reset low between clock edges during RUN at 0:07, and again in EXPIRED.
- Response: outputs return to 0:12 with explode_timer=0 before the next edge.
- Stimulus: start after reset release.
- Response: a normal countdown.
REQ-024 Scenario 6, boundary start.
- Stimulus: START=0:00 with start.
- Response: EXPIRED and explode_timer=1 on the next edge, with no tick.
- Stimulus: START=9:59.
- Response: 9:59 -> 9:58 on the first tick, and 9:00 -> 8:59 on a minute borrow.
